tt_sweep_ctrl: RTL and testbench

- Sequencer for the 3-input combinational circuit block (inputs a, b, c; output z).
- Drives every input vector in ascending order and waits a programmable settle time per vector.
- Captures z into a truth-table register and compares it against a golden table.
- Reports busy, a done pulse, pass, and the first failing vector. Sits between the stimulus/control logic and the circuit under sweep.

---
 rtl/tt_sweep_ctrl_if.sv | 45 ++++
 rtl/tt_sweep_ctrl.sv | 152 +++++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tt_sweep_ctrl_if.sv
// Control/status and circuit-facing signals of the truth-table sweeper.
// The step strobe exists only when TT_SINGLE_STEP_EN is defined.
interface tt_sweep_ctrl_if #(
  parameter int N_IN = 3
);
  localparam int NV = 1 << N_IN;

  logic            start;
  logic            abort;
`ifdef TT_SINGLE_STEP_EN
  logic            step;
`endif
  logic            z;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic [NV-1:0]   tt;
  logic            pass;
  logic [N_IN-1:0] fail_idx;
  logic            fail_valid;

`ifdef TT_SINGLE_STEP_EN
  modport slave (
    input  start, abort, step, z,
    output vec, busy, done, tt,
    output pass, fail_idx, fail_valid
  );
  modport master (
    output start, abort, step, z,
    input  vec, busy, done, tt,
    input  pass, fail_idx, fail_valid
  );
`else
  modport slave (
    input  start, abort, z,
    output vec, busy, done, tt,
    output pass, fail_idx, fail_valid
  );
  modport master (
    output start, abort, z,
    input  vec, busy, done, tt,
    input  pass, fail_idx, fail_valid
  );
`endif
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive input sweeper capturing z into a truth table vs GOLDEN.
// Define TT_SINGLE_STEP_EN to add step-gated vector advance (HOLD).
module tt_sweep_ctrl #(
  parameter int N_IN = 3,
  parameter int SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] GOLDEN = 8'hE8
) (
  input logic            clk,
  input logic            rst_n,
  tt_sweep_ctrl_if.slave bus
);
  localparam int NV = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST = N_IN'(NV - 1);
  localparam logic [3:0] CMAX = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
`ifdef TT_SINGLE_STEP_EN
    , S_HOLD
`endif
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic [N_IN-1:0] r_vec;
  logic [N_IN-1:0] r_fidx;
  logic [NV-1:0]   r_tt;
  logic            r_pass;
  logic            r_fval;

  logic w_init;
  logic w_inc;
  logic w_smp;
  logic w_adv;
  logic w_abt;
  logic w_fin;
  logic w_mis;
  logic w_last;

  assign w_mis  = bus.z != GOLDEN[r_vec];
  assign w_last = r_vec == LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_init = 1'b0;
    w_inc  = 1'b0;
    w_smp  = 1'b0;
    w_adv  = 1'b0;
    w_abt  = 1'b0;
    w_fin  = 1'b0;
    if (r_state != S_IDLE && bus.abort) begin
      w_next = S_IDLE;
      w_abt  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            w_next = S_SETTLE;
            w_init = 1'b1;
          end
        end
        S_SETTLE: begin
          w_inc = 1'b1;
          if (r_cnt == CMAX) w_next = S_SAMPLE;
        end
        S_SAMPLE: begin
          w_smp = 1'b1;
          if (w_last) begin
            w_next = S_DONE;
          end else begin
`ifdef TT_SINGLE_STEP_EN
            w_next = S_HOLD;
`else
            w_next = S_SETTLE;
            w_adv  = 1'b1;
`endif
          end
        end
`ifdef TT_SINGLE_STEP_EN
        S_HOLD: begin
          if (bus.step) begin
            w_next = S_SETTLE;
            w_adv  = 1'b1;
          end
        end
`endif
        S_DONE: begin
          w_next = S_IDLE;
          w_fin  = 1'b1;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_vec  <= '0;
      r_tt   <= '0;
      r_pass <= 1'b0;
      r_fval <= 1'b0;
      r_fidx <= '0;
    end else begin
      if (w_init) begin
        r_cnt  <= '0;
        r_vec  <= '0;
        r_tt   <= '0;
        r_pass <= 1'b0;
        r_fval <= 1'b0;
        r_fidx <= '0;
      end
      // abort keeps the partial table and first-fail record
      if (w_abt) begin
        r_cnt  <= '0;
        r_vec  <= '0;
        r_pass <= 1'b0;
      end
      if (w_fin) r_vec <= '0;
      if (w_inc) r_cnt <= r_cnt + 4'd1;
      if (w_adv) begin
        r_vec <= r_vec + 1'b1;
        r_cnt <= '0;
      end
      if (w_smp) begin
        r_tt[r_vec] <= bus.z;
        if (w_mis && !r_fval) begin
          r_fidx <= r_vec;
          r_fval <= 1'b1;
        end
        if (w_last) r_pass <= !(r_fval || w_mis);
      end
    end
  end

  assign bus.vec        = r_vec;
  assign bus.busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.done       = r_state == S_DONE;
  assign bus.tt         = r_tt;
  assign bus.pass       = r_pass;
  assign bus.fail_idx   = r_fidx;
  assign bus.fail_valid = r_fval;
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Randomized scoreboard bench for tt_sweep_ctrl.
// Expected results come from the truth table applied to z, not the FSM.
module tb_tt_sweep_ctrl;
  localparam int N  = 3;
  localparam int NV = 8;
  localparam int S  = 2;
  localparam logic [7:0] G = 8'hE8;
`ifdef TT_SINGLE_STEP_EN
  localparam int VL = S + 2;
`else
  localparam int VL = S + 1;
`endif
  localparam int LAT = (NV - 1) * VL + S + 1;

  typedef struct {
    logic [7:0] tt;
    logic       pass;
    logic [2:0] fidx;
    logic       fval;
    int         edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] zt;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  exp_t me;

  tt_sweep_ctrl_if #(.N_IN(N)) bus ();

  tt_sweep_ctrl #(
    .N_IN(N),
    .SETTLE(S),
    .GOLDEN(G)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.z = zt[bus.vec];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  // n = number of vectors sampled before the sweep ended
  function automatic exp_t model(input logic [7:0] t, input int e,
                                 input int n);
    exp_t r;
    logic [7:0] g;
    g = G;
    r.tt = '0;
    r.fval = 1'b0;
    r.fidx = '0;
    r.edge_no = e + LAT;
    for (int i = 0; i < n; i++) begin
      r.tt[i] = t[i];
      if (!r.fval && t[i] != g[i]) begin
        r.fval = 1'b1;
        r.fidx = 3'(i);
      end
    end
    r.pass = (n == NV) && !r.fval;
    return r;
  endfunction

  function automatic logic [31:0] outs();
    return 32'({bus.vec, bus.busy, bus.done, bus.tt, bus.pass,
                bus.fail_idx, bus.fail_valid});
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'(sbq.size()), 1);
      end else begin
        me = sbq.pop_front();
        chk("done_edge", cyc, me.edge_no);
        chk("tt", 32'(bus.tt), 32'(me.tt));
        chk("pass", 32'(bus.pass), 32'(me.pass));
        chk("fail_valid", 32'(bus.fail_valid), 32'(me.fval));
        chk("fail_idx", 32'(bus.fail_idx), 32'(me.fidx));
        chk("busy_at_done", 32'(bus.busy), 0);
      end
    end
  end

  task automatic sweep(input logic [7:0] t, input bit noise);
    int e;
    @(negedge clk);
    zt = t;
    bus.start = 1'b1;
    e = cyc + 1;
    sbq.push_back(model(t, e, NV));
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_run", 32'(bus.busy), 1);
    for (int k = 0; k < LAT + 8 && sbq.size() != 0; k++) begin
      @(negedge clk);
      bus.start = (noise && bus.busy) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    bus.start = 1'b0;
    chk("sweep_end", 32'(sbq.size()), 0);
    sbq.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int e;
    int n;
    logic [7:0] t;
    exp_t r;
    bus.start = 1'b0;
    bus.abort = 1'b0;
`ifdef TT_SINGLE_STEP_EN
    bus.step = 1'b1;
`endif
    zt = G;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;

    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    chk("start_abort_idle", outs(), 0);
    bus.start = 1'b0;
    bus.abort = 1'b0;

    sweep(G, 1'b0);
    sweep(8'h00, 1'b0);

    // start held high: one done, then a restart from IDLE
    @(negedge clk);
    zt = 8'($urandom);
    bus.start = 1'b1;
    e = cyc + 1;
    sbq.push_back(model(zt, e, NV));
    sbq.push_back(model(zt, e + LAT + 2, NV));
    for (int k = 0; k < 2 * LAT + 12 && sbq.size() != 0; k++) begin
      @(negedge clk);
      if (sbq.size() == 1 && bus.busy) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    chk("held_start_end", 32'(sbq.size()), 0);
    sbq.delete();
    repeat (3) @(negedge clk);

    // abort sampled 10 edges after start
    @(negedge clk);
    t = 8'($urandom);
    zt = t;
    bus.start = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n = 0;
    for (int k = 0; k < NV; k++) if (S + 1 + k * VL <= 9) n++;
    r = model(t, e, n);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_vec", 32'(bus.vec), 0);
    chk("abort_pass", 32'(bus.pass), 0);
    chk("abort_tt", 32'(bus.tt), 32'(r.tt));
    chk("abort_fval", 32'(bus.fail_valid), 32'(r.fval));
    chk("abort_fidx", 32'(bus.fail_idx), 32'(r.fidx));
    repeat (LAT) @(negedge clk);

    // asynchronous reset mid-sweep
    @(negedge clk);
    zt = 8'($urandom);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs(), 0);
    @(negedge clk);
    chk("reset_hold", outs(), 0);
    rst_n = 1'b1;
    sweep(8'($urandom), 1'b0);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sweep(8'($urandom), 1'b1);
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
